// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - FIFO-buffered pacing and result-capture stage for the serial FIR filter
module fir_sample_feeder #(
  parameter int WIDTH      = 18,
  parameter int TAPS       = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [WIDTH-1:0]              fir_sig,
  output logic                          fir_ready,
  input  logic [WIDTH-1:0]              fir_result,
  output logic [WIDTH-1:0]              m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(TAPS);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PW-1:0]    ph_q;
  logic [PW-1:0]    ph_d;
  logic             load;
  logic             load_q;
  logic             priming_q;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;

  assign s_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign push    = s_valid && s_ready;
  assign fir_sig = mem[rd_ptr];
  assign busy    = (state_q == SWEEP);

  // Input FIFO: registered storage, no fall-through; a load is the only pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sweep state and phase register; ph tracks the filter's tap index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= PW'(TAPS - 1);
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end

  // Load decision and sweep sequencing; a load only starts when the output slot will be free.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    load      = 1'b0;
    fir_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if ((fifo_level != '0) && (!m_valid || m_ready)) begin
          load      = 1'b1;
          fir_ready = 1'b1;
          ph_d      = '0;
          state_d   = SWEEP;
        end
      end
      SWEEP: begin
        fir_ready = 1'b1;
        if (ph_q == PW'(TAPS - 2)) begin
          ph_d    = PW'(TAPS - 1);
          state_d = IDLE;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output capture one cycle after each load; the first load after reset only primes the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q    <= 1'b0;
      priming_q <= 1'b1;
      m_data    <= '0;
      m_valid   <= 1'b0;
    end else begin
      load_q <= load;
      if (load_q) priming_q <= 1'b0;
      if (load_q && !priming_q) begin
        m_data  <= fir_result;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fir_sample_feeder.md
# fir_sample_feeder

Upstream pacing stage for the 64-tap serial FIR filter. Accepts input samples over a valid/ready stream, buffers them in a small FIFO, and drives the filter's `ready` strobe in bursts of exactly TAPS cycles per sample, presenting each sample on the filter input during the burst's first cycle. It also captures the filter's output register after every sample load and re-emits it as a valid/ready output stream, so the filter's handshake-less interface becomes streaming on both sides.

## Interface
Parameters:
- WIDTH, 18, sample width (signed), matches the filter datapath
- TAPS, 64, filter length = `ready` cycles per sample
- FIFO_DEPTH, 8, input FIFO entries, power of two, ≥2

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_data  in  WIDTH  signed input sample
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept; = !full
- fir_sig  out  WIDTH  sample to filter `input_sig`
- fir_ready  out  1  filter `ready` strobe
- fir_result  in  WIDTH  filter `filtred_sig`
- m_data  out  WIDTH  captured filtered sample
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts m_data
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- busy  out  1  high while in SWEEP

## Operation
- FIFO: push on s_valid && s_ready; no fall-through (a sample pushed in cycle t is poppable from t+1). Push+pop in same cycle leaves level unchanged. Pointers wrap modulo FIFO_DEPTH.
- fir_sig = FIFO head entry (mem[rd_ptr]); value only meaningful in a load cycle.
- Phase counter ph (0..TAPS-1) mirrors the filter's read index; reset value TAPS-1.
- FSM IDLE: ph == TAPS-1, fir_ready = 0 unless loading. Load condition: FIFO non-empty AND (!m_valid || m_ready). On load: fir_ready = 1 (combinational), pop FIFO, ph → 0, go SWEEP.
- FSM SWEEP: fir_ready = 1 every cycle, ph increments; in the cycle with ph == TAPS-2, ph → TAPS-1 and state → IDLE. A sweep is therefore TAPS consecutive fir_ready cycles, the first being the load cycle.
- Back-to-back: IDLE may load in its first cycle, so with a non-empty FIFO and a free output slot fir_ready stays high continuously (1 sample / TAPS cycles).
- Capture: in the cycle after each load, register fir_result into m_data and set m_valid, except after the first load since reset (priming flag), whose result is discarded.
- m_valid clears on m_ready when no capture occurs in the same cycle. The load condition guarantees the output slot is empty when a capture occurs. An output result is never lost.
- Width: no arithmetic on sample data; all paths pass WIDTH bits unchanged.

## Timing
- Reset values: s_ready 1, fir_ready 0, fir_sig 0 (FIFO memory cleared), m_data 0, m_valid 0, fifo_level 0, busy 0; state IDLE, ph TAPS-1, priming set.
- Latency: s_data accepted in cycle t into an empty FIFO, idle state, free slot → load cycle t+1, fir_ready high t+1..t+TAPS.
- The filtered value reflecting samples up to load L appears as m_valid in cycle L'+2, where L' is the next load.
- s_ready is low while fifo_level == FIFO_DEPTH; it rises the cycle after a pop.
- If a load is blocked by m_valid && !m_ready, fir_ready stays 0 and the filter freezes.
- Asynchronous reset mid-SWEEP immediately forces fir_ready to 0 and returns the block to reset values. The filter has no reset, so the system asserts rst_n only while busy == 0 to keep ph aligned; the bench checks the feeder's own state only.

## Test plan
- Reset: rst_n low with random inputs → all outputs at reset values; after release, s_ready = 1, fir_ready = 0.
- Single sample: push 18'sd1000 at cycle t → fir_ready high for exactly 64 cycles from t+1, with fir_sig = 1000 at t+1; no m_valid (priming result discarded).
- Stream: push 5 samples back-to-back with m_ready = 1 → fir_ready continuous for 320 cycles; 4 m_valid pulses, each at load+2, with m_data equal to fir_result sampled at load+1 (use a behavioural filter model).
- Backpressure: m_ready = 0 with FIFO holding 3 samples → after one capture, fir_ready stays 0. Raising m_ready → next load the same cycle, no data lost.
- FIFO full: push 9 samples with loads blocked → s_ready drops after 8, fifo_level = 8. One pop → s_ready = 1 the next cycle.
- Reset mid-sweep: drop rst_n at ph = 30 → fir_ready = 0 asynchronously, fifo_level = 0, m_valid = 0; the next sample after release behaves like the first after reset (priming).
